// File: rtl/gpp_pkg.sv
// Shared types and constants for the GPP multi-cycle control unit.
// Also holds the supported-opcode check used by the FSM.
package gpp_pkg;

  typedef enum logic [2:0] {
    S_WAIT    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_STORE   = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

endpackage

// File: rtl/gpp_ctrl_decode.sv
// Combinational Moore decode of (state, opcode) into datapath control signals.
// mem_ready gates IRWrite/PCWrite in FETCH; tied high when memory is single-cycle.
module gpp_ctrl_decode
  import gpp_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_EXECUTE: begin
        case (opcode)
          OP_RTYPE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_FUNCT;
          end
          OP_LW, OP_SW, OP_ADDI: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
          end
          OP_BEQ: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
          end
          OP_J: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = (opcode == OP_LW);
        ctrl.mem_write = (opcode == OP_SW);
      end
      S_STORE: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (opcode == OP_RTYPE);
        ctrl.mem_to_reg = (opcode == OP_LW);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/gpp_control_fsm.sv
// Multi-cycle MIPS control FSM: state register, next-state, IllegalOp and InstrCount.
// Define GPP_MEM_HANDSHAKE_EN to stall FETCH/MEM until MemReady.
//
//  state     | meaning
//  S_WAIT    | idle until Start
//  S_FETCH   | read instruction, PC += 4
//  S_DECODE  | branch target into ALUOut, dispatch on opcode
//  S_EXECUTE | ALU op / branch / jump
//  S_MEM     | data memory access (lw/sw)
//  S_STORE   | register file write-back
module gpp_control_fsm
  import gpp_pkg::*;
#(
  parameter int         CNT_W   = 32,
  parameter logic [5:0] HALT_OP = OP_HALT
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [2:0]       State,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  logic               mem_go;
  logic               retire;
  ctrl_t              ctrl;

  // Zero only matters to the datapath, which gates PCWriteCond with it.
  logic unused_zero;
  assign unused_zero = Zero;

`ifdef GPP_MEM_HANDSHAKE_EN
  assign mem_go = MemReady;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = MemReady;
  assign mem_go = 1'b1;
`endif

  gpp_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (Opcode),
    .mem_ready (mem_go),
    .ctrl      (ctrl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:    if (Start) state_d = S_FETCH;
      S_FETCH:   if (mem_go) state_d = S_DECODE;
      S_DECODE: begin
        if (Opcode == HALT_OP)         state_d = S_WAIT;
        else if (!op_supported(Opcode)) state_d = S_FETCH;
        else                            state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (Opcode)
          OP_RTYPE, OP_ADDI: state_d = S_STORE;
          OP_LW, OP_SW:      state_d = S_MEM;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEM:     if (mem_go) state_d = (Opcode == OP_LW) ? S_STORE : S_FETCH;
      S_STORE:   state_d = S_FETCH;
      default:   state_d = S_WAIT;
    endcase
  end

  assign retire        = (state_d == S_FETCH) &&
                         (state_q inside {S_EXECUTE, S_MEM, S_STORE});
  assign instr_count_d = instr_count_q + CNT_W'(retire);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= S_WAIT;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign IllegalOp   = (state_q == S_DECODE) && (Opcode != HALT_OP) && !op_supported(Opcode);
  assign State       = state_q;
  assign InstrCount  = instr_count_q;
  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;

endmodule

// File: tb/tb_gpp_control_fsm.sv
// Directed bench for gpp_control_fsm: expected per-cycle state/controls/count queued, then compared.
// Also exercises the GPP_MEM_HANDSHAKE_EN stall path when that macro is defined.
module tb_gpp_control_fsm;

  logic        Clk = 1'b0;
  logic        Rst, Start, Zero, MemReady;
  logic [5:0]  Opcode;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        RegDst, MemtoReg, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [2:0]  State;
  logic [31:0] InstrCount;

  gpp_control_fsm dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .State(State), .IllegalOp(IllegalOp), .InstrCount(InstrCount)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] ctl;
    logic [31:0] cnt;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_cnt = 0;
  logic [2:0]  prev_st = 3'd0;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,SrcB,ALUOp,PCSrc}
  function automatic logic [15:0] ctl_model(input logic [2:0] st, input logic [5:0] op,
                                            input logic rdy);
    logic [15:0] c;
    c = 16'h0;
    case (st)
      3'd1: begin c[15] = rdy; c[12] = 1'b1; c[10] = rdy; c[5:4] = 2'b01; end
      3'd2: c[5:4] = 2'b11;
      3'd3: case (op)
        6'h00: begin c[6] = 1'b1; c[3:2] = 2'b10; end
        6'h23, 6'h2B, 6'h08: begin c[6] = 1'b1; c[5:4] = 2'b10; end
        6'h04: begin c[6] = 1'b1; c[3:2] = 2'b01; c[14] = 1'b1; c[1:0] = 2'b01; end
        6'h02: begin c[15] = 1'b1; c[1:0] = 2'b10; end
        default: ;
      endcase
      3'd4: begin c[13] = 1'b1; c[12] = (op == 6'h23); c[11] = (op == 6'h2B); end
      3'd5: begin c[7] = 1'b1; c[9] = (op == 6'h00); c[8] = (op == 6'h23); end
      default: ;
    endcase
    return c;
  endfunction

  task automatic push(input logic [2:0] st, input logic [5:0] op);
    logic rdy;
    logic ill;
`ifdef GPP_MEM_HANDSHAKE_EN
    rdy = MemReady;
`else
    rdy = 1'b1;
`endif
    if (st == 3'd1 && (prev_st inside {3'd3, 3'd4, 3'd5})) exp_cnt = exp_cnt + 1;
    ill = (st == 3'd2) && !(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F});
    sb.push_back('{st, ctl_model(st, op, rdy), exp_cnt, ill});
    prev_st = st;
  endtask

  task automatic compare();
    exp_t        e;
    logic [15:0] obs;
    checks++;
    assert (sb.size() != 0) else begin
      failures++; $error("FAIL scoreboard_empty observed=0 expected=entry");
    end
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
             RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
      checks++;
      assert (State === e.st) else begin
        failures++; $error("FAIL state observed=%0d expected=%0d", State, e.st);
      end
      checks++;
      assert (obs === e.ctl) else begin
        failures++; $error("FAIL ctrl st=%0d observed=%h expected=%h", e.st, obs, e.ctl);
      end
      checks++;
      assert (InstrCount === e.cnt) else begin
        failures++; $error("FAIL instr_count observed=%0d expected=%0d", InstrCount, e.cnt);
      end
      checks++;
      assert (IllegalOp === e.ill) else begin
        failures++; $error("FAIL illegal_op observed=%b expected=%b", IllegalOp, e.ill);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic consume();
    compare();
    tick();
  endtask

  // seq holds up to five 3-bit states, first state in the low bits.
  task automatic run(input logic [5:0] op, input int n, input logic [14:0] seq);
    Opcode = op;
    for (int i = 0; i < n; i++) push(seq[3*i +: 3], op);
    for (int i = 0; i < n; i++) consume();
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; Zero = 1'b1; Opcode = 6'h00;
`ifdef GPP_MEM_HANDSHAKE_EN
    MemReady = 1'b1;
`else
    MemReady = 1'b0;
`endif
    @(negedge Clk);
    push(3'd0, 6'h00); consume();
    Rst = 1'b1;
    push(3'd0, 6'h00); consume();
    push(3'd0, 6'h00); consume();
    Start = 1'b1;
    push(3'd0, 6'h00); consume();
    Start = 1'b0;

    run(6'h00, 4, {3'd0, 3'd5, 3'd3, 3'd2, 3'd1});          // add
    run(6'h23, 5, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1});          // lw
    run(6'h2B, 4, {3'd0, 3'd4, 3'd3, 3'd2, 3'd1});          // sw
    run(6'h04, 3, {3'd0, 3'd0, 3'd3, 3'd2, 3'd1});          // beq
    run(6'h02, 3, {3'd0, 3'd0, 3'd3, 3'd2, 3'd1});          // j
    run(6'h08, 4, {3'd0, 3'd5, 3'd3, 3'd2, 3'd1});          // addi
    run(6'h11, 2, {3'd0, 3'd0, 3'd0, 3'd2, 3'd1});          // illegal

`ifdef GPP_MEM_HANDSHAKE_EN
    MemReady = 1'b0;
    Opcode   = 6'h23;
    for (int i = 0; i < 3; i++) begin push(3'd1, 6'h23); consume(); end
    MemReady = 1'b1;
    run(6'h23, 5, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1});
`endif

    // asynchronous abort in the middle of EXECUTE
    run(6'h00, 2, {3'd0, 3'd0, 3'd0, 3'd2, 3'd1});
    push(3'd3, 6'h00); compare();
    #2 Rst = 1'b0;
    #1;
    exp_cnt = 0; prev_st = 3'd0;
    push(3'd0, 6'h00); compare();
    @(negedge Clk);
    push(3'd0, 6'h00); consume();
    Rst = 1'b1;
    push(3'd0, 6'h00); consume();

    // halt returns to WAIT without retiring
    Start = 1'b1;
    push(3'd0, 6'h3F); consume();
    Start = 1'b0;
    run(6'h3F, 3, {3'd0, 3'd0, 3'd0, 3'd2, 3'd1});
    push(3'd0, 6'h3F); consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
